// File: rtl/ika_slot_timinggen_if.sv
// Slot-bus bundle between the timing generator (master) and its phi1-domain consumers (slave).
// Carries the resync request, the programmable decode settings and every slot-derived output.
interface ika_slot_timinggen_if #(
  parameter int CW = 5
);
  logic          i_SYNC_n;
  logic [CW-1:0] i_MATCH_SLOT;
  logic [CW-1:0] i_RANGE_LO;
  logic [CW-1:0] i_RANGE_HI;
  logic [CW-1:0] o_SLOT;
  logic          o_SLOT_WRAP;
  logic          o_CYCLE_MATCH;
  logic          o_CYCLE_RANGE;
  logic          o_SH1;
  logic          o_SH2;
  logic          o_SYNC_ERR;

  modport master (
    input  i_SYNC_n, i_MATCH_SLOT, i_RANGE_LO, i_RANGE_HI,
    output o_SLOT, o_SLOT_WRAP, o_CYCLE_MATCH, o_CYCLE_RANGE, o_SH1, o_SH2, o_SYNC_ERR
  );

  modport slave (
    output i_SYNC_n, i_MATCH_SLOT, i_RANGE_LO, i_RANGE_HI,
    input  o_SLOT, o_SLOT_WRAP, o_CYCLE_MATCH, o_CYCLE_RANGE, o_SH1, o_SH2, o_SYNC_ERR
  );
endinterface

// File: rtl/ika_slot_timinggen.sv
// Slot timing generator: phiM -> phi1 divider, SLOTS-deep slot counter with resync, SH1/SH2 and
// programmable slot decodes. Defining IKA_TIMINGGEN_SYNC_DETECT_EN builds the sticky resync-error flag.
module ika_slot_timinggen #(
  parameter int SLOTS     = 32,
  parameter int SH_LEN    = 8,
  parameter int SH1_START = 0
) (
  input  logic                 i_EMUCLK,
  input  logic                 i_MRST_n,
  input  logic                 i_phiM_PCEN_n,
  output logic                 o_phi1,
  output logic                 o_phi1_PCEN_n,
  output logic                 o_phi1_NCEN_n,
  ika_slot_timinggen_if.master slot_if
);
  localparam int            CW    = $clog2(SLOTS);
  localparam logic [CW-1:0] LAST  = CW'(SLOTS - 1);
  localparam logic [CW-1:0] SH1_S = CW'(SH1_START % SLOTS);
  localparam logic [CW-1:0] SH2_S = CW'((SH1_START + SLOTS / 2) % SLOTS);
  localparam logic [CW-1:0] SH_L  = CW'(SH_LEN);

  logic          en, pcen, ncen;
  logic          phi1_q;
  logic [CW-1:0] slot_q, slot_d;
  logic [CW-1:0] off1, off2;
  logic          sh1_q, sh1_d, sh2_q, sh2_d;
  logic          range;

  assign en   = ~i_phiM_PCEN_n & i_MRST_n;
  assign pcen = en & ~phi1_q;
  assign ncen = en & phi1_q;

  // SH windows are judged on the slot about to be loaded so the strobes line up with o_SLOT.
  always_comb begin
    slot_d = slot_q + CW'(1);
    if (!slot_if.i_SYNC_n || slot_q == LAST) begin
      slot_d = '0;
    end
    off1  = slot_d - SH1_S;
    off2  = slot_d - SH2_S;
    sh1_d = off1 < SH_L;
    sh2_d = off2 < SH_L;
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      phi1_q <= 1'b0;
      slot_q <= '0;
      sh1_q  <= 1'b0;
      sh2_q  <= 1'b0;
    end else begin
      if (en) begin
        phi1_q <= ~phi1_q;
      end
      if (pcen) begin
        slot_q <= slot_d;
        sh1_q  <= sh1_d;
        sh2_q  <= sh2_d;
      end
    end
  end

`ifdef IKA_TIMINGGEN_SYNC_DETECT_EN
  logic err_q;

  // A resync only counts as an error when it actually yanked the counter away from slot 0.
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      err_q <= 1'b0;
    end else if (pcen && !slot_if.i_SYNC_n && slot_q != '0) begin
      err_q <= 1'b1;
    end
  end

  assign slot_if.o_SYNC_ERR = err_q;
`else
  assign slot_if.o_SYNC_ERR = 1'b0;
`endif

  always_comb begin
    if (slot_if.i_RANGE_LO <= slot_if.i_RANGE_HI) begin
      range = (slot_q >= slot_if.i_RANGE_LO) && (slot_q <= slot_if.i_RANGE_HI);
    end else begin
      range = (slot_q >= slot_if.i_RANGE_LO) || (slot_q <= slot_if.i_RANGE_HI);
    end
  end

  assign o_phi1                = phi1_q;
  assign o_phi1_PCEN_n         = ~pcen;
  assign o_phi1_NCEN_n         = ~ncen;
  assign slot_if.o_SLOT        = slot_q;
  assign slot_if.o_SLOT_WRAP   = slot_q == LAST;
  assign slot_if.o_CYCLE_MATCH = slot_q == slot_if.i_MATCH_SLOT;
  assign slot_if.o_CYCLE_RANGE = range;
  assign slot_if.o_SH1         = sh1_q;
  assign slot_if.o_SH2         = sh2_q;
endmodule

// File: tb/tb_ika_slot_timinggen.sv
// Self-checking bench: a 32-slot and an 8-slot instance compared every cycle against a counting model,
// plus hand-computed literal checks for reset, divider, wrap, decodes, SH windows and resync.
module tb_ika_slot_timinggen;
  logic clk   = 1'b0;
  logic rstN  = 1'b1;
  logic phiMN = 1'b1;
  logic syncN = 1'b1;
  int   matchSlot = 0, rangeLo = 0, rangeHi = 0;

  logic phi1A, pcenA, ncenA, phi1B, pcenB, ncenB;

  int checkCount = 0;
  int errorCount = 0;
  bit compareOn  = 1'b0;

  ika_slot_timinggen_if #(.CW(5)) bus32 ();
  ika_slot_timinggen_if #(.CW(3)) bus8 ();

  assign bus32.i_SYNC_n     = syncN;
  assign bus32.i_MATCH_SLOT = 5'(matchSlot);
  assign bus32.i_RANGE_LO   = 5'(rangeLo);
  assign bus32.i_RANGE_HI   = 5'(rangeHi);
  assign bus8.i_SYNC_n      = syncN;
  assign bus8.i_MATCH_SLOT  = 3'd3;
  assign bus8.i_RANGE_LO    = 3'd6;
  assign bus8.i_RANGE_HI    = 3'd1;

  ika_slot_timinggen #(.SLOTS(32), .SH_LEN(8), .SH1_START(0)) dut (
    .i_EMUCLK(clk), .i_MRST_n(rstN), .i_phiM_PCEN_n(phiMN),
    .o_phi1(phi1A), .o_phi1_PCEN_n(pcenA), .o_phi1_NCEN_n(ncenA), .slot_if(bus32)
  );

  ika_slot_timinggen #(.SLOTS(8), .SH_LEN(2), .SH1_START(1)) dut8 (
    .i_EMUCLK(clk), .i_MRST_n(rstN), .i_phiM_PCEN_n(phiMN),
    .o_phi1(phi1B), .o_phi1_PCEN_n(pcenB), .o_phi1_NCEN_n(ncenB), .slot_if(bus8)
  );

  always #5 clk = ~clk;

  // phiM enable low on every second EMUCLK, changed just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1 phiMN = ~phiMN;
    end
  end

  // Model: phi1 is the parity of enables since reset; a slot is the count of phi1 rises since the last resync.
  int enCount = 0, pcenCount = 0, since32 = 0, since8 = 0;
  bit shValid = 1'b0, err32 = 1'b0, err8 = 1'b0;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      enCount = 0; pcenCount = 0; since32 = 0; since8 = 0;
      shValid = 1'b0; err32 = 1'b0; err8 = 1'b0;
    end else if (!phiMN) begin
      if (enCount % 2 == 0) begin
        pcenCount++;
        shValid = 1'b1;
        if (!syncN) begin
          if (since32 % 32 != 0) err32 = 1'b1;
          if (since8 % 8 != 0) err8 = 1'b1;
          since32 = 0;
          since8  = 0;
        end else begin
          since32++;
          since8++;
        end
      end
      enCount++;
    end
  end

  function automatic bit inRange(int s, int lo, int hi, int n);
    return ((s - lo + n) % n) <= ((hi - lo + n) % n);
  endfunction

  function automatic bit shOn(int s, int start, int len, int n);
    return ((s - start + n) % n) < len;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checkCount++;
    errorCount++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  bit enNow, phiNow, e32, e8;
  int s32, s8;

  always @(negedge clk) begin
    if (compareOn) begin
      enNow  = !phiMN && rstN;
      phiNow = (enCount % 2) == 1;
      s32    = since32 % 32;
      s8     = since8 % 8;
`ifdef IKA_TIMINGGEN_SYNC_DETECT_EN
      e32 = err32;
      e8  = err8;
`else
      e32 = 1'b0;
      e8  = 1'b0;
`endif
      checkOutput("phi1", 32'(phi1A), 32'(phiNow));
      checkOutput("pcen_n", 32'(pcenA), 32'(!(enNow && !phiNow)));
      checkOutput("ncen_n", 32'(ncenA), 32'(!(enNow && phiNow)));
      checkOutput("slot", 32'(bus32.o_SLOT), 32'(s32));
      checkOutput("wrap", 32'(bus32.o_SLOT_WRAP), 32'(s32 == 31));
      checkOutput("match", 32'(bus32.o_CYCLE_MATCH), 32'(s32 == matchSlot));
      checkOutput("range", 32'(bus32.o_CYCLE_RANGE), 32'(inRange(s32, rangeLo, rangeHi, 32)));
      checkOutput("sh1", 32'(bus32.o_SH1), 32'(shValid && shOn(s32, 0, 8, 32)));
      checkOutput("sh2", 32'(bus32.o_SH2), 32'(shValid && shOn(s32, 16, 8, 32)));
      checkOutput("sync_err", 32'(bus32.o_SYNC_ERR), 32'(e32));
      checkOutput("phi1_8", 32'(phi1B), 32'(phiNow));
      checkOutput("pcen_n_8", 32'(pcenB), 32'(!(enNow && !phiNow)));
      checkOutput("ncen_n_8", 32'(ncenB), 32'(!(enNow && phiNow)));
      checkOutput("slot_8", 32'(bus8.o_SLOT), 32'(s8));
      checkOutput("wrap_8", 32'(bus8.o_SLOT_WRAP), 32'(s8 == 7));
      checkOutput("match_8", 32'(bus8.o_CYCLE_MATCH), 32'(s8 == 3));
      checkOutput("range_8", 32'(bus8.o_CYCLE_RANGE), 32'(inRange(s8, 6, 1, 8)));
      checkOutput("sh1_8", 32'(bus8.o_SH1), 32'(shValid && shOn(s8, 1, 2, 8)));
      checkOutput("sh2_8", 32'(bus8.o_SH2), 32'(shValid && shOn(s8, 5, 2, 8)));
      checkOutput("sync_err_8", 32'(bus8.o_SYNC_ERR), 32'(e8));
    end
  end

  task automatic applyStimulus(input int m, input int lo, input int hi);
    @(negedge clk);
    matchSlot = m;
    rangeLo   = lo;
    rangeHi   = hi;
  endtask

  task automatic waitSlot(input int target);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (since32 % 32 == target) return;
    end
    timeoutFail($sformatf("wait_slot_%0d", target));
  endtask

  task automatic pulseSync();
    int c;
    @(negedge clk);
    syncN = 1'b0;
    c = pcenCount;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pcenCount != c) break;
    end
    if (pcenCount == c) timeoutFail("sync_pcen");
    syncN = 1'b1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_phi1"}, 32'(phi1A), 32'd0);
    checkOutput({tag, "_slot"}, 32'(bus32.o_SLOT), 32'd0);
    checkOutput({tag, "_sh1"}, 32'(bus32.o_SH1), 32'd0);
    checkOutput({tag, "_sh2"}, 32'(bus32.o_SH2), 32'd0);
    checkOutput({tag, "_pcen_n"}, 32'(pcenA), 32'd1);
    checkOutput({tag, "_ncen_n"}, 32'(ncenA), 32'd1);
    checkOutput({tag, "_err"}, 32'(bus32.o_SYNC_ERR), 32'd0);
    checkOutput({tag, "_slot8"}, 32'(bus8.o_SLOT), 32'd0);
  endtask

  int pc, nc, both;
  logic expErr;

  initial begin
    applyStimulus(5, 30, 2);
    #2 rstN = 1'b0;
    compareOn = 1'b1;
    repeat (3) @(negedge clk);
    #2 checkResetState("reset");
    @(negedge clk);
    #2 rstN = 1'b1;

    // Divider: any 40-EMUCLK window holds exactly ten strobes of each kind.
    pc = 0; nc = 0; both = 0;
    repeat (40) begin
      @(negedge clk);
      if (!pcenA) pc++;
      if (!ncenA) nc++;
      if (!pcenA && !ncenA) both++;
    end
    checkOutput("div_pcen_count", 32'(pc), 32'd10);
    checkOutput("div_ncen_count", 32'(nc), 32'd10);
    checkOutput("div_overlap", 32'(both), 32'd0);

    // Wrap, decodes (MATCH=5, LO=30, HI=2) and SH windows within one frame.
    waitSlot(29); checkOutput("range_29", 32'(bus32.o_CYCLE_RANGE), 32'd0);
    waitSlot(30); checkOutput("range_30", 32'(bus32.o_CYCLE_RANGE), 32'd1);
    checkOutput("wrap_30", 32'(bus32.o_SLOT_WRAP), 32'd0);
    waitSlot(31); checkOutput("wrap_31", 32'(bus32.o_SLOT_WRAP), 32'd1);
    checkOutput("range_31", 32'(bus32.o_CYCLE_RANGE), 32'd1);
    waitSlot(0); checkOutput("wrap_0", 32'(bus32.o_SLOT_WRAP), 32'd0);
    checkOutput("slot_0", 32'(bus32.o_SLOT), 32'd0);
    checkOutput("range_0", 32'(bus32.o_CYCLE_RANGE), 32'd1);
    checkOutput("sh1_0", 32'(bus32.o_SH1), 32'd1);
    waitSlot(2); checkOutput("range_2", 32'(bus32.o_CYCLE_RANGE), 32'd1);
    waitSlot(3); checkOutput("range_3", 32'(bus32.o_CYCLE_RANGE), 32'd0);
    waitSlot(4); checkOutput("match_4", 32'(bus32.o_CYCLE_MATCH), 32'd0);
    waitSlot(5); checkOutput("match_5", 32'(bus32.o_CYCLE_MATCH), 32'd1);
    waitSlot(7); checkOutput("sh1_7", 32'(bus32.o_SH1), 32'd1);
    waitSlot(8); checkOutput("sh1_8", 32'(bus32.o_SH1), 32'd0);
    waitSlot(15); checkOutput("sh2_15", 32'(bus32.o_SH2), 32'd0);
    waitSlot(16); checkOutput("sh2_16", 32'(bus32.o_SH2), 32'd1);
    checkOutput("slot_16", 32'(bus32.o_SLOT), 32'd16);
    waitSlot(23); checkOutput("sh2_23", 32'(bus32.o_SH2), 32'd1);
    waitSlot(24); checkOutput("sh2_24", 32'(bus32.o_SH2), 32'd0);

    begin
      bit seen7 = 1'b0;
      for (int k = 0; k < 80 && !seen7; k++) begin
        @(negedge clk);
        if (since8 % 8 == 7) begin
          seen7 = 1'b1;
          checkOutput("wrap8_slot", 32'(bus8.o_SLOT), 32'd7);
          checkOutput("wrap8_flag", 32'(bus8.o_SLOT_WRAP), 32'd1);
        end
      end
      if (!seen7) timeoutFail("wait_slot8_7");
    end

    // Resync at slot 0 (no error), at 13 (error when built), at 31 (flag stays).
`ifdef IKA_TIMINGGEN_SYNC_DETECT_EN
    expErr = 1'b1;
`else
    expErr = 1'b0;
`endif
    waitSlot(0); pulseSync();
    checkOutput("sync0_slot", 32'(bus32.o_SLOT), 32'd0);
    checkOutput("sync0_err", 32'(bus32.o_SYNC_ERR), 32'd0);
    waitSlot(13); pulseSync();
    checkOutput("sync13_slot", 32'(bus32.o_SLOT), 32'd0);
    checkOutput("sync13_err", 32'(bus32.o_SYNC_ERR), 32'(expErr));
    waitSlot(31); pulseSync();
    checkOutput("sync31_slot", 32'(bus32.o_SLOT), 32'd0);
    checkOutput("sync31_err", 32'(bus32.o_SYNC_ERR), 32'(expErr));

    // Non-wrapping and single-slot ranges, left to the per-cycle comparison.
    applyStimulus(0, 10, 12);
    repeat (140) @(negedge clk);
    applyStimulus(31, 20, 20);
    waitSlot(20); checkOutput("range_single_20", 32'(bus32.o_CYCLE_RANGE), 32'd1);
    waitSlot(21); checkOutput("range_single_21", 32'(bus32.o_CYCLE_RANGE), 32'd0);

    // Mid-frame reset clears without a clock edge.
    waitSlot(20);
    #2 rstN = 1'b0;
    #1 checkResetState("midrst");
    @(negedge clk);
    #2 checkResetState("midrst_hold");
    @(negedge clk);
    #2 rstN = 1'b1;
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end
endmodule
